// File: rtl/myproject_div_pkg.sv
// Shared types and constants for the sequential unsigned divider.
// Defaults match the 3x8->10 multiplier that this divider inverts.
package myproject_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_DIVIDEND_W = 10;
    localparam int DIV_DIVISOR_W  = 3;
    localparam int DIV_QUOT_W     = 8;
    localparam int DIV_CNT_W      = $clog2(DIV_DIVIDEND_W);

    localparam logic [DIV_QUOT_W-1:0] QUOT_MAX = '1;

    // Iteration counter width; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/myproject_udiv_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract.
// Combinational, zero latency.
// No flow control; the caller sequences it once per cycle.
module myproject_udiv_step
    import myproject_div_pkg::*;
#(
    parameter int DIVISOR_WIDTH = DIV_DIVISOR_W
) (
    input  logic [DIVISOR_WIDTH-1:0] prem,
    input  logic                     next_bit,
    input  logic [DIVISOR_WIDTH-1:0] divisor,
    output logic [DIVISOR_WIDTH-1:0] prem_next,
    output logic                     q_bit
);

    logic [DIVISOR_WIDTH:0] trial;

    assign trial = {prem, next_bit};
    assign q_bit = (trial >= {1'b0, divisor});

    // The kept value is always below the divisor, so it fits DIVISOR_WIDTH bits.
    assign prem_next = DIVISOR_WIDTH'(q_bit ? (trial - {1'b0, divisor}) : trial);

endmodule

// File: rtl/myproject_udiv_seq.sv
// Sequential radix-2 restoring unsigned divider with saturating quotient.
// Latency DIVIDEND_WIDTH cycles from accept to out_valid (1 cycle for divide-by-zero).
// Single operation in flight; in_ready low until the result is taken via out_ready.
module myproject_udiv_seq
    import myproject_div_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = DIV_DIVIDEND_W,
    parameter int DIVISOR_WIDTH  = DIV_DIVISOR_W,
    parameter int QUOT_WIDTH     = DIV_QUOT_W
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [QUOT_WIDTH-1:0]     quot,
    output logic [DIVISOR_WIDTH-1:0]  rem,
    output logic                      ovf,
    output logic                      dbz
);

    localparam int CW = cnt_width(DIVIDEND_WIDTH);
    localparam logic [QUOT_WIDTH-1:0] QSAT = '1;

    div_state_t                state;
    logic [DIVIDEND_WIDTH-1:0] dvd_sh;
    logic [DIVISOR_WIDTH-1:0]  divr;
    logic [DIVISOR_WIDTH-1:0]  prem;
    logic [CW-1:0]             cnt;

    logic [DIVISOR_WIDTH-1:0]  prem_next;
    logic                      q_bit;
    logic [DIVIDEND_WIDTH-1:0] q_full;
    logic                      q_ovf;

    myproject_udiv_step #(
        .DIVISOR_WIDTH (DIVISOR_WIDTH)
    ) u_step (
        .prem      (prem),
        .next_bit  (dvd_sh[DIVIDEND_WIDTH-1]),
        .divisor   (divr),
        .prem_next (prem_next),
        .q_bit     (q_bit)
    );

    // Dividend bits leave at the top while quotient bits enter at the bottom,
    // so after the last iteration the shift register holds the full quotient.
    assign q_full = {dvd_sh[DIVIDEND_WIDTH-2:0], q_bit};
    assign q_ovf  = ((q_full >> QUOT_WIDTH) != '0);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quot      <= '0;
            rem       <= '0;
            ovf       <= 1'b0;
            dbz       <= 1'b0;
            dvd_sh    <= '0;
            divr      <= '0;
            prem      <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        divr     <= divisor;
                        ovf      <= 1'b0;
                        dbz      <= 1'b0;
                        in_ready <= 1'b0;
                        if (divisor == '0) begin
                            dbz   <= 1'b1;
                            quot  <= QSAT;
                            rem   <= dividend[DIVISOR_WIDTH-1:0];
                            state <= DONE;
                        end else begin
                            dvd_sh <= dividend;
                            prem   <= '0;
                            cnt    <= CW'(DIVIDEND_WIDTH - 1);
                            state  <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    dvd_sh <= q_full;
                    prem   <= prem_next;
                    if (cnt == '0) begin
                        rem       <= prem_next;
                        ovf       <= q_ovf;
                        quot      <= q_ovf ? QSAT : q_full[QUOT_WIDTH-1:0];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    // Divide-by-zero enters DONE with out_valid low; raise it one cycle later.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_myproject_udiv_seq.sv
// Bench for myproject_udiv_seq: directed literal cases plus randomised traffic
// checked every cycle against an arithmetic reference model.
module tb_myproject_udiv_seq;

    logic       ap_clk    = 1'b0;
    logic       ap_rst    = 1'b1;
    logic       in_valid  = 1'b0;
    logic       in_ready;
    logic [9:0] dividend  = '0;
    logic [2:0] divisor   = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] quot;
    logic [2:0] rem;
    logic       ovf;
    logic       dbz;

    always #5 ap_clk = ~ap_clk;

    myproject_udiv_seq #(
        .DIVIDEND_WIDTH (10),
        .DIVISOR_WIDTH  (3),
        .QUOT_WIDTH     (8)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot      (quot),
        .rem       (rem),
        .ovf       (ovf),
        .dbz       (dbz)
    );

    typedef struct {
        int dvd;
        int dvs;
        int q;
        int r;
        int o;
        int d;
        int acc;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   armed  = 1'b0;
    bit   rnd    = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference result straight from integer division.
    function automatic exp_t model(input int dvd, input int dvs, input int acc);
        exp_t e;
        int   full;
        e.dvd = dvd;
        e.dvs = dvs;
        e.acc = acc;
        if (dvs == 0) begin
            e.q   = 255;
            e.r   = dvd % 8;
            e.o   = 0;
            e.d   = 1;
            e.lat = 1;
        end else begin
            full  = dvd / dvs;
            e.o   = (full > 255) ? 1 : 0;
            e.q   = e.o ? 255 : full;
            e.r   = dvd % dvs;
            e.d   = 0;
            e.lat = 10;
        end
        return e;
    endfunction

    // Compare process: every cycle after reset, judge handshakes and result fields.
    always @(negedge ap_clk) begin
        cyc++;
        if (armed) begin : cmp
            bit ev;
            ev = (sb.size() > 0) && (cyc >= sb[0].acc + sb[0].lat + 1);
            chk("in_ready", int'(in_ready), int'(sb.size() == 0));
            chk("out_valid", int'(out_valid), int'(ev));
            if (ev && out_valid) begin
                chk("quot", int'(quot), sb[0].q);
                chk("rem", int'(rem), sb[0].r);
                chk("ovf", int'(ovf), sb[0].o);
                chk("dbz", int'(dbz), sb[0].d);
                if (!dbz && !ovf) begin
                    chk("identity", int'(quot) * sb[0].dvs + int'(rem), sb[0].dvd);
                    chk("rem_lt_div", int'(int'(rem) < sb[0].dvs), 1);
                end
            end
        end
        if (ap_rst) begin
            sb.delete();
            armed = 1'b1;
        end else begin
            if (out_valid && out_ready && sb.size() > 0)
                void'(sb.pop_front());
            if (in_valid && in_ready)
                sb.push_back(model(int'(dividend), int'(divisor), cyc));
        end
    end

    // Present operands until accepted; returns just after the accepting edge.
    task automatic do_op(input int dvd, input int dvs);
        int n;
        @(posedge ap_clk);
        #1;
        dividend = 10'(dvd);
        divisor  = 3'(dvs);
        in_valid = 1'b1;
        n = 0;
        @(negedge ap_clk);
        while (!in_ready && n < 100) begin
            @(negedge ap_clk);
            n++;
        end
        chk("accept", int'(in_ready), 1);
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait for out_valid and compare against hand-computed literals.
    task automatic expect_result(input string nm, input int q, input int r,
                                 input int o, input int d, input int lat);
        int k;
        k = 0;
        do begin
            @(negedge ap_clk);
            k++;
        end while (!out_valid && k < 50);
        chk({nm, "_valid"}, int'(out_valid), 1);
        chk({nm, "_latency"}, k, lat + 1);
        chk({nm, "_quot"}, int'(quot), q);
        chk({nm, "_rem"}, int'(rem), r);
        chk({nm, "_ovf"}, int'(ovf), o);
        chk({nm, "_dbz"}, int'(dbz), d);
    endtask

    initial begin
        int n;

        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_quot", int'(quot), 0);
        chk("rst_rem", int'(rem), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_dbz", int'(dbz), 0);
        @(posedge ap_clk);
        #1;
        ap_rst    = 1'b0;
        out_ready = 1'b1;

        do_op(765, 3);
        expect_result("d765_3", 255, 0, 0, 0, 10);

        @(posedge ap_clk);
        #1;
        out_ready = 1'b0;
        do_op(1023, 7);
        expect_result("d1023_7", 146, 1, 0, 0, 10);
        for (int i = 0; i < 5; i++) begin
            @(negedge ap_clk);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_quot", int'(quot), 146);
            chk("bp_rem", int'(rem), 1);
        end
        @(posedge ap_clk);
        #1;
        out_ready = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        chk("bp_release_valid", int'(out_valid), 0);
        chk("bp_release_ready", int'(in_ready), 1);

        do_op(1023, 1);
        expect_result("d1023_1", 255, 0, 1, 0, 10);
        do_op(300, 2);
        expect_result("d300_2", 150, 0, 0, 0, 10);

        do_op(13, 0);
        expect_result("d13_0", 255, 5, 0, 1, 1);

        do_op(999, 5);
        repeat (4) @(posedge ap_clk);
        #1;
        ap_rst = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        @(negedge ap_clk);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out_valid", int'(out_valid), 0);
        do_op(999, 5);
        expect_result("d999_5", 199, 4, 0, 0, 10);

        rnd = 1'b1;
        fork
            begin
                for (int i = 0; i < 2000; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge ap_clk);
                    do_op(int'($urandom_range(0, 1023)), int'($urandom_range(0, 7)));
                end
                rnd = 1'b0;
            end
            begin
                while (rnd) begin
                    @(posedge ap_clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join

        @(posedge ap_clk);
        #1;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge ap_clk);
            n++;
        end
        chk("drain", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
